mem_port_arbiter: RTL and testbench

Shares the single-port 16-bit unified memory between two requesters: the CPU control path (fetch/load/store) and a program loader/debug port.
Runs a 3-state access sequencer with round-robin arbitration and an optional loader burst lock; a saturating lock counter bounds how long the CPU can be starved.
Sits between the requesters and the memory block; the CPU FSM stalls on its request until ack.

---
 rtl/arb_pkg.sv | 25 ++
 rtl/arb_lock_ctr.sv | 56 +++++
 rtl/mem_port_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and constants for the memory port arbiter.
//   - arb_state_e : access sequencer states (IDLE -> GNT -> RESP -> IDLE)
//   - arb_owner_e : which requester owns (or last owned) the memory port
//   - DEF_MAX_LOCK: default bound on consecutive locked loader grants
//   - STAT_W      : width of the optional statistics counters (ARB_STATS_EN)
// -----------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GNT  = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } arb_owner_e;

  localparam int unsigned DEF_MAX_LOCK = 8;
  localparam int unsigned STAT_W       = 16;

endpackage

// File: rtl/arb_lock_ctr.sv
// -----------------------------------------------------------------------------
// arb_lock_ctr
// Saturating up-counter with synchronous clear. Bounds loader burst
// ownership in the arbiter, and doubles as a saturating event counter for
// the optional statistics outputs.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset, clears the count
//   clr  : synchronous clear (has priority over inc)
//   inc  : increment request, ignored once saturated
//   cnt  : current count
//   sat  : 1 when cnt == MAX_LOCK
// -----------------------------------------------------------------------------
module arb_lock_ctr
  import arb_pkg::*;
#(
  parameter int unsigned MAX_LOCK = DEF_MAX_LOCK,
  parameter int unsigned W        = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  localparam logic [W-1:0] MAX_V = W'(MAX_LOCK);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = (cnt_q == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between the CPU control path and the
// program loader/debug port. Each access runs IDLE -> GNT -> RESP; the
// memory is driven during GNT, the read data is captured at the end of GNT
// and returned with a one-cycle ack in RESP. Ties are resolved round-robin;
// the loader may hold a burst lock, bounded by MAX_LOCK grants while the CPU
// is waiting.
// Ports:
//   clk, rst                        : clock / async active-low reset
//   cpu_req/we/addr/wdata           : CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata              : CPU completion pulse and read data
//   ldr_req/we/addr/wdata, ldr_lock : loader request and burst lock
//   ldr_ack, ldr_rdata              : loader completion pulse and read data
//   mem_we/addr/wdata, mem_rdata    : memory port (mem_rdata combinational)
//   busy                            : 1 while an access is in flight
// Optional build macro ARB_STATS_EN adds cpu_gnt_cnt, ldr_gnt_cnt and
// cpu_wait_cnt (16-bit saturating counters).
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_LOCK = DEF_MAX_LOCK,
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  output logic              cpu_ack,
  output logic [DW-1:0]     cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [AW-1:0]     ldr_addr,
  input  logic [DW-1:0]     ldr_wdata,
  input  logic              ldr_lock,
  output logic              ldr_ack,
  output logic [DW-1:0]     ldr_rdata,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic              busy
`ifdef ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] cpu_gnt_cnt,
  output logic [STAT_W-1:0] ldr_gnt_cnt,
  output logic [STAT_W-1:0] cpu_wait_cnt
`endif
);

  arb_state_e    state_q, state_d;
  arb_owner_e    owner_q, owner_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic       gnt_cpu, gnt_ldr;
  logic       lock_active, lock_sat, lock_clr, lock_inc;
  logic [7:0] unused_lock_cnt;  // only saturation matters for arbitration

  // The lock only protects an ongoing loader burst, and only until the
  // loader has taken MAX_LOCK grants over a waiting CPU.
  assign lock_active = (owner_q == OWN_LDR) && ldr_lock && !lock_sat;

  always_comb begin
    gnt_cpu = 1'b0;
    gnt_ldr = 1'b0;
    if (state_q == ST_IDLE) begin
      if (lock_active) begin
        gnt_ldr = ldr_req;
      end else if (cpu_req && ldr_req) begin
        // Round-robin: the requester that did not own the port last wins.
        gnt_cpu = (owner_q == OWN_LDR);
        gnt_ldr = (owner_q == OWN_CPU);
      end else begin
        gnt_cpu = cpu_req;
        gnt_ldr = ldr_req;
      end
    end
  end

  // Loader grants only count against the lock while the CPU is waiting.
  assign lock_clr = gnt_cpu || ((state_q == ST_IDLE) && !ldr_lock);
  assign lock_inc = gnt_ldr && ldr_lock && cpu_req;

  arb_lock_ctr #(
    .MAX_LOCK (MAX_LOCK),
    .W        (8)
  ) u_lock_ctr (
    .clk (clk),
    .rst (rst),
    .clr (lock_clr),
    .inc (lock_inc),
    .cnt (unused_lock_cnt),
    .sat (lock_sat)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_cpu || gnt_ldr) begin
          state_d = ST_GNT;
          owner_d = gnt_cpu ? OWN_CPU : OWN_LDR;
        end
      end
      ST_GNT: begin
        state_d = ST_RESP;
        // Captured even on writes: returns the pre-write contents.
        rdata_d = mem_rdata;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Owner resets to LDR so that the CPU wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_LDR;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory port is driven only in GNT, so an async reset during GNT drops
  // mem_we before the edge and the write never lands.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ST_GNT) begin
      if (owner_q == OWN_CPU) begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end else begin
        mem_we    = ldr_we;
        mem_addr  = ldr_addr;
        mem_wdata = ldr_wdata;
      end
    end
  end

  assign cpu_ack   = (state_q == ST_RESP) && (owner_q == OWN_CPU);
  assign ldr_ack   = (state_q == ST_RESP) && (owner_q == OWN_LDR);
  assign cpu_rdata = cpu_ack ? rdata_q : '0;
  assign ldr_rdata = ldr_ack ? rdata_q : '0;
  assign busy      = (state_q != ST_IDLE);

`ifdef ARB_STATS_EN
  logic cpu_wait_inc;
  logic unused_cpu_gnt_sat, unused_ldr_gnt_sat, unused_cpu_wait_sat;

  assign cpu_wait_inc = (state_q == ST_IDLE) && cpu_req && !gnt_cpu;

  arb_lock_ctr #(
    .MAX_LOCK ((1 << STAT_W) - 1),
    .W        (STAT_W)
  ) u_cpu_gnt_ctr (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (gnt_cpu),
    .cnt (cpu_gnt_cnt),
    .sat (unused_cpu_gnt_sat)
  );

  arb_lock_ctr #(
    .MAX_LOCK ((1 << STAT_W) - 1),
    .W        (STAT_W)
  ) u_ldr_gnt_ctr (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (gnt_ldr),
    .cnt (ldr_gnt_cnt),
    .sat (unused_ldr_gnt_sat)
  );

  arb_lock_ctr #(
    .MAX_LOCK ((1 << STAT_W) - 1),
    .W        (STAT_W)
  ) u_cpu_wait_ctr (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (cpu_wait_inc),
    .cnt (cpu_wait_cnt),
    .sat (unused_cpu_wait_sat)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter (MAX_LOCK=3): a table of
// single-access vectors from reset, hand-written multi-cycle sequences
// (latency, write-then-read, alternation, lock burst, reset mid-write) and a
// randomized run against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int MAXL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        ldr_req, ldr_we, ldr_lock, ldr_ack;
  logic [15:0] ldr_addr, ldr_wdata, ldr_rdata;
  logic        mem_we, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_STATS_EN
  logic [15:0] cpu_gnt_cnt, ldr_gnt_cnt, cpu_wait_cnt;
`endif

  mem_port_arbiter #(.MAX_LOCK(MAXL), .AW(16), .DW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .ldr_req   (ldr_req),
    .ldr_we    (ldr_we),
    .ldr_addr  (ldr_addr),
    .ldr_wdata (ldr_wdata),
    .ldr_lock  (ldr_lock),
    .ldr_ack   (ldr_ack),
    .ldr_rdata (ldr_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
`ifdef ARB_STATS_EN
    ,
    .cpu_gnt_cnt  (cpu_gnt_cnt),
    .ldr_gnt_cnt  (ldr_gnt_cnt),
    .cpu_wait_cnt (cpu_wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- memory
  logic [15:0] mem [256];
  logic        init_req = 1'b0;

  function automatic logic [15:0] init_val(input int i);
    if (i == 4) return 16'hBEEF;
    return (16'(i) * 16'h0101) ^ 16'h5A5A;
  endfunction

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------- checking
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [67:0] mk_obs(input logic ca, input logic la, input logic b,
                                         input logic we, input logic [15:0] a,
                                         input logic [15:0] wd, input logic [15:0] cr,
                                         input logic [15:0] lr);
    return {ca, la, b, we, a, wd, cr, lr};
  endfunction

  function automatic logic [67:0] obs();
    return mk_obs(cpu_ack, ldr_ack, busy, mem_we, mem_addr, mem_wdata, cpu_rdata, ldr_rdata);
  endfunction

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0; ldr_lock = 1'b0;
  endtask

  task automatic init_mem();
    init_req = 1'b1;
    @(posedge clk);
    #1 init_req = 1'b0;
  endtask

  // Leaves the bench at a falling edge with rst just released.
  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic        cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
    logic [15:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
    logic        exp_cpu_ack, exp_ldr_ack;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  // ---------------------------------------------------------------- model
  logic [15:0] mm [256];
  logic [67:0] expq [$];
  bit          m_owner_ldr;
  int          m_cnt;
  bit          cpu_pend, ldr_pend;

  initial begin
    logic [67:0] e;
    logic [1:0]  exp_pair [18];
    bit          gc, gl, was_idle;
    logic [15:0] rd;

    idle_inputs();
    init_mem();

    //               creq cwe lreq lwe lock caddr    cwdata   laddr    lwdata   eca ela rdata
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0003, 16'h0000, 1'b0, 1'b1, init_val(3)};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000, 16'h0006, 16'h0000, 1'b1, 1'b0, init_val(5)};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0007, 16'h0000, 1'b0, 1'b1, init_val(7)};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0008, 16'h1111, 16'h0000, 16'h0000, 1'b1, 1'b0, init_val(8)};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0009, 16'h0000, 16'h0009, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h1111};

    // Reset state, sampled while reset is asserted.
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", obs(), '0);

    // Table: one access from reset, result observed in the RESP cycle.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      cpu_req = vecs[v].cpu_req; cpu_we = vecs[v].cpu_we;
      cpu_addr = vecs[v].cpu_addr; cpu_wdata = vecs[v].cpu_wdata;
      ldr_req = vecs[v].ldr_req; ldr_we = vecs[v].ldr_we; ldr_lock = vecs[v].ldr_lock;
      ldr_addr = vecs[v].ldr_addr; ldr_wdata = vecs[v].ldr_wdata;
      @(negedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", v),
            {cpu_ack, ldr_ack, cpu_rdata, ldr_rdata},
            {vecs[v].exp_cpu_ack, vecs[v].exp_ldr_ack,
             vecs[v].exp_cpu_ack ? vecs[v].exp_rdata : 16'h0,
             vecs[v].exp_ldr_ack ? vecs[v].exp_rdata : 16'h0});
      idle_inputs();
      @(negedge clk);
    end

    // CPU read latency: ack exactly 2 cycles after the request is sampled.
    do_reset();
    check("post_reset_outputs", obs(), '0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0004;
    @(negedge clk);
    check("rd_gnt_cycle", obs(), mk_obs(1'b0, 1'b0, 1'b1, 1'b0, 16'h0004, 16'h0, 16'h0, 16'h0));
    @(negedge clk);
    check("rd_ack_cycle", obs(), mk_obs(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'hBEEF, 16'h0));
    cpu_req = 1'b0;
    @(negedge clk);
    check("rd_back_idle", obs(), '0);

    // Loader write, then CPU reads it back.
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 16'h0010; ldr_wdata = 16'h1234;
    @(negedge clk);
    check("wr_gnt_cycle", obs(), mk_obs(1'b0, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h1234, 16'h0, 16'h0));
    @(negedge clk);
    check("wr_ack_cycle", obs(), mk_obs(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, init_val(16)));
    idle_inputs();
    cpu_req = 1'b1; cpu_addr = 16'h0010;
    @(negedge clk);
    check("wr_then_idle", obs(), '0);
    @(negedge clk);
    check("rb_gnt_cycle", obs(), mk_obs(1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, 16'h0, 16'h0));
    @(negedge clk);
    check("rb_ack_cycle", obs(), mk_obs(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h1234, 16'h0));
    idle_inputs();

    // Both requesting from reset: CPU, LDR, CPU, LDR, one ack every 3 cycles.
    do_reset();
    cpu_req = 1'b1; cpu_addr = 16'h0004;
    ldr_req = 1'b1; ldr_addr = 16'h0003;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("alt_cyc%0d", k), {cpu_ack, ldr_ack},
            (k % 3 != 2) ? 2'b00 : (((k / 3) % 2 == 0) ? 2'b10 : 2'b01));
    end
    idle_inputs();

    // Lock burst: CPU first, then 3 locked loader grants, CPU, loader again.
    do_reset();
    cpu_req = 1'b1; cpu_addr = 16'h0004;
    ldr_req = 1'b1; ldr_addr = 16'h0003;
    for (int k = 0; k < 18; k++) exp_pair[k] = 2'b00;
    exp_pair[1]  = 2'b10;
    exp_pair[4]  = 2'b01;
    exp_pair[7]  = 2'b01;
    exp_pair[10] = 2'b01;
    exp_pair[13] = 2'b10;
    exp_pair[16] = 2'b01;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      ldr_lock = 1'b1;
      check($sformatf("lock_cyc%0d", k + 1), {cpu_ack, ldr_ack}, exp_pair[k]);
    end
    idle_inputs();

    // Reset during the GNT cycle of a write aborts it.
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'hCAFE;
    @(negedge clk);
    check("abort_gnt", obs(), mk_obs(1'b0, 1'b0, 1'b1, 1'b1, 16'h0020, 16'hCAFE, 16'h0, 16'h0));
    rst = 1'b0;
    idle_inputs();
    #1;
    check("abort_outs_now", obs(), '0);
    @(negedge clk);
    check("abort_mem_kept", {52'h0, mem[8'h20]}, {52'h0, init_val(32)});
    rst = 1'b1;
    @(negedge clk);
    check("abort_no_ack", obs(), '0);

    // Randomized run against the transaction-level model.
    rst = 1'b0;
    init_mem();
    do_reset();
    for (int i = 0; i < 256; i++) mm[i] = init_val(i);
    expq.delete();
    m_owner_ldr = 1'b1;
    m_cnt = 0;
    cpu_pend = 1'b0;
    ldr_pend = 1'b0;
    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      was_idle = (expq.size() == 0);
      e = was_idle ? 68'h0 : expq.pop_front();
      check($sformatf("rand_cyc%0d", c), obs(), e);
      if (e[67]) cpu_pend = 1'b0;
      if (e[66]) ldr_pend = 1'b0;
      if (!cpu_pend && ($urandom_range(0, 2) != 0)) begin
        cpu_pend  = 1'b1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 16'($urandom_range(0, 15));
        cpu_wdata = 16'($urandom);
      end
      if (!ldr_pend && ($urandom_range(0, 2) != 0)) begin
        ldr_pend  = 1'b1;
        ldr_we    = 1'($urandom_range(0, 1));
        ldr_addr  = 16'($urandom_range(0, 15));
        ldr_wdata = 16'($urandom);
      end
      cpu_req  = cpu_pend;
      ldr_req  = ldr_pend;
      ldr_lock = ($urandom_range(0, 3) != 0);
      if (was_idle) begin
        gc = 1'b0;
        gl = 1'b0;
        if (m_owner_ldr && ldr_lock && (m_cnt < MAXL)) gl = ldr_req;
        else if (cpu_req && ldr_req) begin
          gc = m_owner_ldr;
          gl = !m_owner_ldr;
        end else begin
          gc = cpu_req;
          gl = ldr_req;
        end
        if (gc || !ldr_lock) m_cnt = 0;
        if (gl && ldr_lock && cpu_req && (m_cnt < MAXL)) m_cnt++;
        if (gc) begin
          rd = mm[cpu_addr[7:0]];
          expq.push_back(mk_obs(1'b0, 1'b0, 1'b1, cpu_we, cpu_addr, cpu_wdata, 16'h0, 16'h0));
          expq.push_back(mk_obs(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, rd, 16'h0));
          if (cpu_we) mm[cpu_addr[7:0]] = cpu_wdata;
          m_owner_ldr = 1'b0;
        end
        if (gl) begin
          rd = mm[ldr_addr[7:0]];
          expq.push_back(mk_obs(1'b0, 1'b0, 1'b1, ldr_we, ldr_addr, ldr_wdata, 16'h0, 16'h0));
          expq.push_back(mk_obs(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, rd));
          if (ldr_we) mm[ldr_addr[7:0]] = ldr_wdata;
          m_owner_ldr = 1'b1;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
